// File: rtl/output_signature_compactor.sv
// rtl/output_signature_compactor.sv - MISR compactor for a wide output bus with a serial MSB-first signature dump
module output_signature_compactor #(
    parameter int                   DATA_WIDTH = 64,
    parameter int                   SIG_WIDTH  = 32,
    parameter logic [SIG_WIDTH-1:0] POLY       = 32'h04C1_1DB7,
    parameter logic [SIG_WIDTH-1:0] SEED       = {SIG_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  clear,
    input  logic                  dump_req,
    output logic                  sig_out,
    output logic                  sig_out_valid,
    output logic                  frame_start
);

    localparam int CNT_W  = $clog2(SIG_WIDTH);
    localparam int NCHUNK = (DATA_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
    localparam int PAD_W  = NCHUNK * SIG_WIDTH;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [SIG_WIDTH-1:0] sig;
    logic [SIG_WIDTH-1:0] sig_upd;
    logic [SIG_WIDTH-1:0] shadow;
    logic [CNT_W-1:0]     counter;
    logic [PAD_W-1:0]     padded;
    logic [SIG_WIDTH-1:0] fold_acc [NCHUNK+1];

    // Zero-extending to a whole number of chunks pads the last chunk at its MSB end.
    assign padded      = PAD_W'(data_in);
    assign fold_acc[0] = '0;

    for (genvar c = 0; c < NCHUNK; c++) begin : g_fold
        assign fold_acc[c+1] = fold_acc[c] ^ padded[c*SIG_WIDTH +: SIG_WIDTH];
    end

    always_comb begin
        sig_upd = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : '0) ^ fold_acc[NCHUNK];
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sig <= SEED;
        end else if (data_valid) begin
            sig <= sig_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dump_req) state_next = SHIFT;
            SHIFT:   if (counter == CNT_W'(SIG_WIDTH - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The snapshot is taken from the registered sig, so a same-cycle fold or clear is not visible in it.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            counter <= '0;
        end else if (state == IDLE && dump_req) begin
            shadow  <= sig;
            counter <= '0;
        end else if (state == SHIFT) begin
            shadow  <= {shadow[SIG_WIDTH-2:0], 1'b0};
            counter <= counter + 1'b1;
        end
    end

    assign sig_out       = (state == SHIFT) && shadow[SIG_WIDTH-1];
    assign sig_out_valid = (state == SHIFT);
    assign frame_start   = (state == SHIFT) && (counter == '0);

endmodule

// File: tb/tb_output_signature_compactor.sv
// tb/tb_output_signature_compactor.sv - self-checking bench: constant fold table, scoreboarded dump frames, reference MISR
module tb_output_signature_compactor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_reset = 1'b1, s_valid = 1'b0, s_clear = 1'b0, s_dump = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_out, s_ov, s_fs;

    logic       p_reset = 1'b1, p_valid = 1'b0, p_clear = 1'b0, p_dump = 1'b0;
    logic [5:0] p_data = '0;
    logic       p_out, p_ov, p_fs;

    logic        d_reset = 1'b1, d_valid = 1'b0, d_clear = 1'b0, d_dump = 1'b0;
    logic [63:0] d_data = '0;
    logic        d_out, d_ov, d_fs;

    output_signature_compactor #(.DATA_WIDTH(8), .SIG_WIDTH(4), .POLY(4'h3), .SEED(4'h0)) dut_s (
        .clk(clk), .reset(s_reset), .data_in(s_data), .data_valid(s_valid), .clear(s_clear),
        .dump_req(s_dump), .sig_out(s_out), .sig_out_valid(s_ov), .frame_start(s_fs));

    output_signature_compactor #(.DATA_WIDTH(6), .SIG_WIDTH(4), .POLY(4'h3), .SEED(4'h0)) dut_p (
        .clk(clk), .reset(p_reset), .data_in(p_data), .data_valid(p_valid), .clear(p_clear),
        .dump_req(p_dump), .sig_out(p_out), .sig_out_valid(p_ov), .frame_start(p_fs));

    output_signature_compactor dut_d (
        .clk(clk), .reset(d_reset), .data_in(d_data), .data_valid(d_valid), .clear(d_clear),
        .dump_req(d_dump), .sig_out(d_out), .sig_out_valid(d_ov), .frame_start(d_fs));

    typedef struct {
        logic b;
        logic fs;
        int   cyc;
    } bit_t;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       clr;
        logic [3:0] exp;
    } vec_t;

    bit_t        qs[$];
    bit_t        qd[$];
    vec_t        tbl[10];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    bit          mon_s  = 1'b0;
    bit          mon_d  = 1'b0;
    logic [3:0]  ms     = 4'h0;
    logic [31:0] md     = 32'hFFFF_FFFF;
    int          busy_s = 0;
    int          busy_d = 0;

    function automatic logic [3:0] misr4(input logic [3:0] s, input logic [7:0] d);
        return {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0) ^ d[3:0] ^ d[7:4];
    endfunction

    function automatic logic [31:0] misr32(input logic [31:0] s, input logic [63:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ d[31:0] ^ d[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step_s(input logic r, input logic v, input logic [7:0] d, input logic c,
                          input logic dump, input logic use_exp, input logic [3:0] exp);
        logic [3:0] snap;
        s_reset = r; s_valid = v; s_data = d; s_clear = c; s_dump = dump;
        if (r) begin
            while (qs.size() > 0 && qs[$].cyc > cyc) void'(qs.pop_back());
            ms = 4'h0;
            busy_s = 0;
        end else begin
            if (busy_s == 0 && dump) begin
                snap = use_exp ? exp : ms;
                for (int k = 0; k < 4; k++) qs.push_back(bit_t'{b: snap[3-k], fs: (k == 0), cyc: cyc + 1 + k});
                busy_s = 4;
            end else if (busy_s > 0) begin
                busy_s--;
            end
            if (c) ms = 4'h0;
            else if (v) ms = misr4(ms, d);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic step_d(input logic r, input logic v, input logic [63:0] d, input logic c, input logic dump);
        d_reset = r; d_valid = v; d_data = d; d_clear = c; d_dump = dump;
        if (r) begin
            while (qd.size() > 0 && qd[$].cyc > cyc) void'(qd.pop_back());
            md = 32'hFFFF_FFFF;
            busy_d = 0;
        end else begin
            if (busy_d == 0 && dump) begin
                for (int k = 0; k < 32; k++) qd.push_back(bit_t'{b: md[31-k], fs: (k == 0), cyc: cyc + 1 + k});
                busy_d = 32;
            end else if (busy_d > 0) begin
                busy_d--;
            end
            if (c) md = 32'hFFFF_FFFF;
            else if (v) md = misr32(md, d);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    // Every cycle: either the next expected frame bit is due now, or all outputs must be quiet.
    always @(negedge clk) begin
        if (mon_s) begin : mon_small
            bit_t e;
            logic ev;
            while (qs.size() > 0 && qs[0].cyc < cyc) begin
                check("s_missed_bit", 1'b0, 1'b1);
                void'(qs.pop_front());
            end
            ev = (qs.size() > 0) && (qs[0].cyc == cyc);
            check("s_sig_out_valid", s_ov, ev);
            if (ev) begin
                e = qs.pop_front();
                check("s_sig_out", s_out, e.b);
                check("s_frame_start", s_fs, e.fs);
            end else begin
                check("s_idle_outputs", {s_out, s_fs}, 2'b00);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_d) begin : mon_default
            bit_t e;
            logic ev;
            while (qd.size() > 0 && qd[0].cyc < cyc) begin
                check("d_missed_bit", 1'b0, 1'b1);
                void'(qd.pop_front());
            end
            ev = (qd.size() > 0) && (qd[0].cyc == cyc);
            check("d_sig_out_valid", d_ov, ev);
            if (ev) begin
                e = qd.pop_front();
                check("d_sig_out", d_out, e.b);
                check("d_frame_start", d_fs, e.fs);
            end else begin
                check("d_idle_outputs", {d_out, d_fs}, 2'b00);
            end
        end
    end

    initial begin
        logic [3:0] pexp;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 4'hF};
        tbl[1] = '{8'h00, 1'b1, 1'b0, 4'hD};
        tbl[2] = '{8'hFF, 1'b0, 1'b0, 4'hD};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 4'h0};
        tbl[4] = '{8'h3C, 1'b1, 1'b0, 4'hF};
        tbl[5] = '{8'h12, 1'b1, 1'b0, 4'hE};
        tbl[6] = '{8'h81, 1'b1, 1'b0, 4'h6};
        tbl[7] = '{8'h0F, 1'b0, 1'b0, 4'h6};
        tbl[8] = '{8'h77, 1'b1, 1'b0, 4'hC};
        tbl[9] = '{8'h00, 1'b1, 1'b0, 4'hB};

        // Reset, quiet idle, then a dump of the seed.
        step_s(1, 0, 8'h00, 0, 0, 0, 4'h0);
        step_s(1, 0, 8'h00, 0, 0, 0, 4'h0);
        mon_s = 1'b1;
        repeat (5) step_s(0, 0, 8'h00, 0, 0, 0, 4'h0);
        step_s(0, 0, 8'h00, 0, 1, 1, 4'h0);
        repeat (5) step_s(0, 0, 8'h00, 0, 0, 0, 4'h0);

        for (int i = 0; i < 10; i++) begin
            step_s(0, tbl[i].valid, tbl[i].data, tbl[i].clr, 0, 0, 4'h0);
            step_s(0, 0, 8'h00, 0, 1, 1, tbl[i].exp);
            repeat (5) step_s(0, 0, 8'h00, 0, 0, 0, 4'h0);
        end

        // dump_req held across a frame while the MISR keeps folding.
        for (int i = 0; i < 10; i++) step_s(0, 1, 8'($urandom), 0, 1, 0, 4'h0);
        repeat (6) step_s(0, 0, 8'h00, 0, 0, 0, 4'h0);

        // Reset on the third bit of a frame.
        step_s(0, 1, 8'h5A, 0, 0, 0, 4'h0);
        step_s(0, 0, 8'h00, 0, 1, 0, 4'h0);
        repeat (2) step_s(0, 0, 8'h00, 0, 0, 0, 4'h0);
        step_s(1, 0, 8'h00, 0, 0, 0, 4'h0);
        repeat (2) step_s(0, 0, 8'h00, 0, 0, 0, 4'h0);
        step_s(0, 0, 8'h00, 0, 1, 1, 4'h0);
        repeat (5) step_s(0, 0, 8'h00, 0, 0, 0, 4'h0);

        // Padding: 6-bit bus into a 4-bit signature.
        repeat (2) begin @(posedge clk); #1; end
        p_reset = 1'b0; p_valid = 1'b1; p_data = 6'b11_0101;
        @(posedge clk); #1;
        p_valid = 1'b0; p_dump = 1'b1;
        @(posedge clk); #1;
        p_dump = 1'b0;
        pexp = 4'h6;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("p_sig_out_valid", p_ov, 1'b1);
            check("p_sig_out", p_out, pexp[3-k]);
            check("p_frame_start", p_fs, (k == 0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("p_valid_after_frame", p_ov, 1'b0);
        @(posedge clk); #1;

        // Default parameters against the reference MISR.
        step_d(1, 0, 64'h0, 0, 0);
        step_d(1, 0, 64'h0, 0, 0);
        mon_d = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            step_d(0, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                   ($urandom_range(0, 63) == 0), (i % 100 == 0));
        end
        repeat (40) step_d(0, 0, 64'h0, 0, 0);

        check("s_queue_drained", 64'(qs.size()), 64'd0);
        check("d_queue_drained", 64'(qd.size()), 64'd0);
        mon_s = 1'b0;
        mon_d = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
